// File: rtl/diff_frame_stats.sv
// Per-frame statistics (sum, min, max, negative count) over a stream of signed
// 9-bit differences. Results are held in DONE until the consumer accepts them.
module diff_frame_stats #(
   parameter int FRAME_LEN = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [8:0]  diff,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [16:0] sum,
   output logic [8:0]  min_d,
   output logic [8:0]  max_d,
   output logic [8:0]  neg_cnt
);

   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

   localparam logic [8:0] LAST_IDX = 9'(FRAME_LEN - 1);

   state_t      r_state;
   logic [16:0] r_sum;
   logic [8:0]  r_min;
   logic [8:0]  r_max;
   logic [8:0]  r_neg_cnt;
   logic [8:0]  r_count;
   logic        r_first;

   logic        w_accept;
   logic        w_last;
   logic        w_lt_min;
   logic        w_gt_max;
   logic [16:0] w_diff_ext;

   assign w_accept   = in_valid && (r_state == ACCUM);
   assign w_last     = (r_count == LAST_IDX);
   assign w_diff_ext = {{8{diff[8]}}, diff};
   assign w_lt_min   = $signed(diff) < $signed(r_min);
   assign w_gt_max   = $signed(diff) > $signed(r_max);

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; mixing in blocking assignments here would create races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ACCUM;
         r_sum     <= '0;
         r_min     <= '0;
         r_max     <= '0;
         r_neg_cnt <= '0;
         r_count   <= '0;
         r_first   <= 1'b1;
      end else if (clear) begin
         // Abort outranks both sample acceptance and the result handshake.
         r_state   <= ACCUM;
         r_sum     <= '0;
         r_min     <= '0;
         r_max     <= '0;
         r_neg_cnt <= '0;
         r_count   <= '0;
         r_first   <= 1'b1;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_sum     <= r_sum + w_diff_ext;
                  r_neg_cnt <= r_neg_cnt + {8'd0, diff[8]};
                  r_count   <= r_count + 9'd1;
                  r_first   <= 1'b0;
                  if (r_first) begin
                     r_min <= diff;
                     r_max <= diff;
                  end else begin
                     if (w_lt_min) r_min <= diff;
                     if (w_gt_max) r_max <= diff;
                  end
                  if (w_last) r_state <= DONE;
               end
            end
            DONE: begin
               // min/max are reloaded by the next frame's first sample.
               if (out_ready) begin
                  r_state   <= ACCUM;
                  r_sum     <= '0;
                  r_neg_cnt <= '0;
                  r_count   <= '0;
                  r_first   <= 1'b1;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign min_d     = r_min;
   assign max_d     = r_max;
   assign neg_cnt   = r_neg_cnt;

endmodule

// File: tb/tb_diff_frame_stats.sv
// Randomised scoreboard bench for diff_frame_stats: a queue-based frame model
// predicts each result, a negedge monitor compares whatever the DUT presents.
module tb_diff_frame_stats;

   typedef struct packed {
      logic [16:0] sum;
      logic [8:0]  mn;
      logic [8:0]  mx;
      logic [8:0]  neg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [8:0]  diff = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [16:0] sum;
   logic [8:0]  min_d;
   logic [8:0]  max_d;
   logic [8:0]  neg_cnt;

   logic        b_clear = 1'b0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [8:0]  b_diff = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [16:0] b_sum;
   logic [8:0]  b_min_d;
   logic [8:0]  b_max_d;
   logic [8:0]  b_neg_cnt;

   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   bit   pending = 1'b0;
   int   smp[256];
   int   nsmp = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   diff_frame_stats #(.FRAME_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .diff(diff),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .min_d(min_d), .max_d(max_d), .neg_cnt(neg_cnt)
   );

   diff_frame_stats #(.FRAME_LEN(256)) dut_big (
      .clk(clk), .rst_n(rst_n), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .diff(b_diff),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .sum(b_sum), .min_d(b_min_d), .max_d(b_max_d), .neg_cnt(b_neg_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame statistics straight from the definition, over the first n samples.
   function automatic exp_t compute(input int n);
      exp_t r;
      int s, mn, mx, ng;
      s = 0; ng = 0; mn = smp[0]; mx = smp[0];
      for (int i = 0; i < n; i++) begin
         s += smp[i];
         if (smp[i] < mn) mn = smp[i];
         if (smp[i] > mx) mx = smp[i];
         if (smp[i] < 0) ng++;
      end
      r.sum = 17'(s);
      r.mn  = 9'(mn);
      r.mx  = 9'(mx);
      r.neg = 9'(ng);
      return r;
   endfunction

   // Drive one cycle on the FRAME_LEN=4 DUT and advance the frame model.
   task automatic cycle(input logic v, input logic [8:0] d, input logic ordy, input logic clr);
      in_valid  = v;
      diff      = d;
      out_ready = ordy;
      clear     = clr;
      @(posedge clk);
      if (clr) begin
         if (pending) void'(exp_q.pop_front());
         pending = 1'b0;
         nsmp    = 0;
      end else if (pending) begin
         if (ordy) pending = 1'b0;
      end else if (v) begin
         smp[nsmp] = $signed(d);
         nsmp++;
         if (nsmp == 4) begin
            exp_q.push_back(compute(4));
            nsmp    = 0;
            pending = 1'b1;
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", {31'd0, out_valid}, {31'd0, pending});
         check("in_ready", {31'd0, in_ready}, {31'd0, !pending});
         if (out_valid) begin
            check("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               check("sum", {15'd0, sum}, {15'd0, exp_q[0].sum});
               check("min_d", {23'd0, min_d}, {23'd0, exp_q[0].mn});
               check("max_d", {23'd0, max_d}, {23'd0, exp_q[0].mx});
               check("neg_cnt", {23'd0, neg_cnt}, {23'd0, exp_q[0].neg});
               if (out_ready && !clear) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      exp_t be;
      int   r;

      // Reset state, asserted before any clock edge.
      #2;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {15'd0, sum}, 32'd0);
      check("rst_min", {23'd0, min_d}, 32'd0);
      check("rst_max", {23'd0, max_d}, 32'd0);
      check("rst_neg", {23'd0, neg_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Mixed-sign frame, then a held result with in_valid asserted.
      cycle(1, 9'd5, 0, 0);
      cycle(1, 9'h1FD, 0, 0);
      cycle(1, 9'd0, 0, 0);
      cycle(1, 9'd255, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 9'($urandom_range(511, 0)), 0, 0);
      cycle(0, 9'd0, 1, 0);
      cycle(0, 9'd0, 0, 0);

      // Abort a partial frame with clear.
      cycle(1, 9'd100, 0, 0);
      cycle(1, 9'd100, 0, 0);
      cycle(0, 9'd0, 0, 1);
      for (int i = 1; i <= 4; i++) cycle(1, 9'(i), 0, 0);
      cycle(0, 9'd0, 1, 0);

      // Gapped input must yield the same frame.
      for (int i = 1; i <= 4; i++) begin
         cycle(1, 9'(i), 0, 0);
         cycle(0, 9'd0, 0, 0);
      end
      cycle(0, 9'd0, 1, 0);

      // Asynchronous reset between edges, mid-frame.
      cycle(1, 9'd7, 0, 0);
      cycle(1, 9'd7, 0, 0);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("async_sum", {15'd0, sum}, 32'd0);
      check("async_max", {23'd0, max_d}, 32'd0);
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_in_ready", {31'd0, in_ready}, 32'd1);
      nsmp = 0;
      pending = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) cycle(1, 9'd7, 0, 0);
      cycle(0, 9'd0, 1, 0);

      // Randomised traffic: gaps, back-pressure, occasional clear.
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(510, 0)) - 255;
         cycle($urandom_range(3, 0) != 0, 9'(r), $urandom_range(2, 0) != 0,
               $urandom_range(40, 0) == 0);
      end
      for (int i = 0; i < 3; i++) cycle(0, 9'd0, 1, 0);
      check("exp_q_drained", exp_q.size(), 32'd0);

      // FRAME_LEN=256 extreme: all samples -255.
      for (int i = 0; i < 256; i++) smp[i] = -255;
      be = compute(256);
      for (int i = 0; i < 256; i++) begin
         b_in_valid = 1'b1;
         b_diff = 9'h101;
         @(posedge clk);
         #1;
         if (i == 254) check("big_not_done_early", {31'd0, b_out_valid}, 32'd0);
      end
      b_in_valid = 1'b0;
      check("big_out_valid", {31'd0, b_out_valid}, 32'd1);
      check("big_in_ready", {31'd0, b_in_ready}, 32'd0);
      check("big_sum", {15'd0, b_sum}, {15'd0, be.sum});
      check("big_min", {23'd0, b_min_d}, {23'd0, be.mn});
      check("big_max", {23'd0, b_max_d}, {23'd0, be.mx});
      check("big_neg", {23'd0, b_neg_cnt}, {23'd0, be.neg});
      b_out_ready = 1'b1;
      @(posedge clk);
      #1;
      b_out_ready = 1'b0;
      check("big_release_valid", {31'd0, b_out_valid}, 32'd0);
      check("big_release_ready", {31'd0, b_in_ready}, 32'd1);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/diff_frame_stats.md
DIFF_FRAME_STATS -- requirements
Module: diff_frame_stats

Interface
REQ-001 Parameter: FRAME_LEN, default 16, samples per frame, legal range 2..256.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous frame abort, active-high.
REQ-005 in_valid  input  1  diff sample present.
REQ-006 in_ready  output  1  block can accept a sample.
REQ-007 diff  input  9  difference from the 8-bit subtractor stage (a-b), 9-bit two's complement; value range -255..+255; diff[8] is borrow.
REQ-008 out_valid  output  1  frame result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 sum  output  17  signed sum of frame samples.
REQ-011 min_d  output  9  signed minimum sample of frame.
REQ-012 max_d  output  9  signed maximum sample of frame.
REQ-013 neg_cnt  output  9  count of frame samples with diff[8]=1.

Function
REQ-014 States SHALL be exactly ACCUM and DONE.
REQ-015 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 in ACCUM and 0 in DONE.
REQ-016 Each accepted sample SHALL be sign-extended to 17 bits and added to the running sum; no saturation needed (bound -65280..+65280).
REQ-017 The first accepted sample of a frame SHALL load min and max; later samples SHALL update them by signed comparison.
REQ-018 neg_cnt SHALL increment by 1 per accepted sample with diff[8]=1.
REQ-019 A sample counter SHALL count accepted samples; on acceptance of sample number FRAME_LEN, the FSM SHALL go ACCUM->DONE.
REQ-020 out_valid SHALL be 1 exactly while in DONE, i.e. rising the cycle after the last sample is accepted (latency 1).
REQ-021 In DONE, sum/min_d/max_d/neg_cnt SHALL hold final frame values, stable until handshake.
REQ-022 On out_valid=1 and out_ready=1, FSM SHALL go DONE->ACCUM and clear sum, neg_cnt, counter, and first-sample flag in that edge.
REQ-023 in_valid in DONE SHALL be ignored; no sample is lost or double-counted.
REQ-024 In ACCUM, outputs sum/min_d/max_d/neg_cnt SHALL show running values (don't-care to consumer; out_valid=0).
REQ-025 clear=1 SHALL, on the next edge, force ACCUM, zero all accumulators and counter, drop out_valid; clear SHALL take priority over sample acceptance and result handshake in the same cycle.
REQ-026 Peak throughput SHALL be one sample per cycle within a frame, with a minimum of one DONE cycle between frames.
REQ-027 in_valid gaps SHALL not change any frame result.

Reset
REQ-028 rst_n=0 SHALL immediately force ACCUM, in_ready=1, out_valid=0, sum=0, min_d=0, max_d=0, neg_cnt=0, counter=0, independent of clk.
REQ-029 Reset asserted mid-frame or in DONE SHALL discard the partial/pending result; first frame after release starts from sample 1.

Verification (bench uses FRAME_LEN=4 unless stated)
REQ-030 Samples 5, 9'h1FD (-3), 0, 255 back-to-back -> next cycle out_valid=1, sum=257, min_d=9'h1FD, max_d=255, neg_cnt=1.
REQ-031 FRAME_LEN=256, all samples 9'h101 (-255) -> sum=-65280 (17'h10100), min_d=max_d=9'h101, neg_cnt=256.
REQ-032 Frame done, out_ready=0 for 5 cycles with in_valid=1 -> outputs unchanged, in_ready=0, no samples counted; out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-033 Two samples (100, 100), clear pulse, then 1, 2, 3, 4 -> sum=10, min_d=1, max_d=4, neg_cnt=0.
REQ-034 rst_n low asynchronously mid-frame (between edges) -> outputs zero immediately, out_valid=0; following frame 7,7,7,7 -> sum=28.
REQ-035 Samples 1,2,3,4 with in_valid toggling every other cycle -> sum=10, min_d=1, max_d=4, same as back-to-back.
